// File: rtl/pipe_issue_ctrl_if.sv
// pipe_issue_ctrl_if
//   Bundles the host job request, the pipeline issue strobe and the finish
//   handshake seen by pipe_issue_ctrl.
//   master : controller side (drives busy/done/error, pipe_clr/enable, in_valid/in_index)
//   slave  : host + datapath side (drives start/len, stall, finish)
interface pipe_issue_ctrl_if #(
    parameter int CntWidth = 16
);
    logic                start;
    logic [CntWidth-1:0] len;
    logic                busy;
    logic                done;
    logic                error;
    logic                pipe_clr;
    logic                enable;
    logic                stall;
    logic                in_valid;
    logic [CntWidth-1:0] in_index;
    logic                finish;

    modport master (
        input  start, len, stall, finish,
        output busy, done, error, pipe_clr, enable, in_valid, in_index
    );

    modport slave (
        output start, len, stall, finish,
        input  busy, done, error, pipe_clr, enable, in_valid, in_index
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
//   Initiator side of the pipeline start/finish handshake. Takes a job of
//   len items from the host, re-arms the finish counter with a one-cycle
//   pipe_clr, pulses enable, issues one in_valid strobe per item while
//   stall is low, then waits for finish (or a timeout) and reports done/error.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   bus (master)   : start/len in, busy/done/error out, pipe_clr/enable out,
//                    stall in, in_valid/in_index out, finish in
module pipe_issue_ctrl #(
    parameter int CntWidth      = 16,
    parameter int TimeoutCycles = 1024,
    parameter int TmoWidth      = 11
) (
    input  logic              clk,
    input  logic              rst,
    pipe_issue_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [CntWidth-1:0] len_q;
    logic [CntWidth-1:0] idx_q;
    logic [TmoWidth-1:0] tmo_q;

    logic busy_q, done_q, error_q, clr_q, en_q;
    logic busy_d, done_d, error_d, clr_d, en_d;

    logic issue, last_issue, tmo_hit;

    // in_valid is the only output that follows stall combinationally.
    assign issue      = (state == ISSUE) && !bus.stall;
    // Compare against len-1 rather than waiting for idx==len so a job of
    // all-ones length never needs the index to wrap.
    assign last_issue = issue && (idx_q == len_q - CntWidth'(1));
    assign tmo_hit    = (tmo_q == TmoWidth'(TimeoutCycles - 1));

    // State register and datapath counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            clr_q   <= clr_d;
            en_q    <= en_d;

            if (state == IDLE && bus.start && bus.len != '0)
                len_q <= bus.len;

            if (state == CLEAR)
                idx_q <= '0;
            else if (issue)
                idx_q <= idx_q + CntWidth'(1);

            // Zero on DRAIN entry, counting only while draining.
            tmo_q <= (state == DRAIN) ? tmo_q + TmoWidth'(1) : '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = (bus.len != '0) ? CLEAR : DONE;
            CLEAR: state_nx = ISSUE;
            ISSUE: if (last_issue) state_nx = DRAIN;
            DRAIN: if (bus.finish || tmo_hit) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: values computed from the coming state, loaded into flops
    // so the pulses line up with the state they belong to.
    always_comb begin
        busy_d  = (state_nx != IDLE);
        clr_d   = (state_nx == CLEAR);
        en_d    = (state == CLEAR);
        done_d  = (state_nx == DONE);
        // finish wins over a timeout landing in the same cycle
        error_d = (state == DRAIN) && !bus.finish && tmo_hit;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.pipe_clr = clr_q;
    assign bus.enable   = en_q;
    assign bus.in_valid = issue;
    assign bus.in_index = idx_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
module tb_pipe_issue_ctrl;
    localparam int CW  = 4;
    localparam int TMO = 8;
    localparam int MAXLEN = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_issue_ctrl_if #(.CntWidth(CW)) bus ();

    pipe_issue_ctrl #(.CntWidth(CW), .TimeoutCycles(TMO), .TmoWidth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Job-level reference: m_cyc counts cycles since the job was accepted,
    // m_iss items issued so far, m_drn cycles spent waiting for finish.
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    bit m_fresh = 1'b1;
    int m_cyc = 0, m_len = 0, m_iss = 0, m_drn = -1;

    task automatic step(input bit s, input int l, input bit st, input bit fi, input bit r);
        bit e_vld;
        @(negedge clk);
        bus.start  = s;
        bus.len    = CW'(l);
        bus.stall  = st;
        bus.finish = fi;
        rst        = r;
        #1;
        e_vld = m_act && m_cyc >= 2 && m_iss < m_len && !st;
        chk("busy",     32'(bus.busy),     32'(m_act || m_done));
        chk("done",     32'(bus.done),     32'(m_done));
        chk("error",    32'(bus.error),    32'(m_done && m_err));
        chk("pipe_clr", 32'(bus.pipe_clr), 32'(m_act && m_cyc == 1));
        chk("enable",   32'(bus.enable),   32'(m_act && m_cyc == 2));
        chk("in_valid", 32'(bus.in_valid), 32'(e_vld));
        if (e_vld)        chk("in_index", 32'(bus.in_index), 32'(m_iss));
        else if (m_fresh) chk("idx_rst",  32'(bus.in_index), 32'd0);

        // advance the reference across the coming edge
        if (r) begin
            m_act = 0; m_done = 0; m_err = 0; m_fresh = 1;
        end else if (m_done) begin
            m_done = 0; m_err = 0;
        end else if (!m_act) begin
            if (s) begin
                if (l == 0) begin
                    m_done = 1; m_err = 0;
                end else begin
                    m_act = 1; m_cyc = 1; m_len = l; m_iss = 0; m_drn = -1; m_fresh = 0;
                end
            end
        end else if (m_drn >= 0) begin
            if (fi)                   begin m_act = 0; m_done = 1; m_err = 0; end
            else if (m_drn == TMO-1)  begin m_act = 0; m_done = 1; m_err = 1; end
            else m_drn++;
        end else begin
            if (e_vld) begin
                m_iss++;
                if (m_iss == m_len) m_drn = 0;
            end
            m_cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.len = '0; bus.stall = 0; bus.finish = 0;
        @(posedge clk);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(2);

        // plain job, finish three cycles into the wait
        step(1, 4, 0, 0, 0); idle(5); step(0, 0, 0, 0, 0); idle(2);
        step(0, 0, 0, 1, 0); idle(3);

        // stall across the first issue cycles
        step(1, 3, 0, 0, 0); step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        idle(4); step(0, 0, 0, 1, 0); idle(2);

        // zero-length job
        step(1, 0, 0, 0, 0); idle(3);

        // no finish at all: timeout path
        step(1, 2, 0, 0, 0); idle(15);

        // finish asserted early is ignored until the wait phase
        step(1, 2, 0, 1, 0); repeat (5) step(0, 0, 0, 1, 0); idle(2);

        // reset in the middle of issuing, then a clean job
        step(1, 5, 0, 0, 0); idle(3); step(0, 0, 0, 0, 1); idle(2);
        step(1, 2, 0, 0, 0); idle(4); step(0, 0, 0, 1, 0); idle(2);

        // start pulsed while busy, including the done cycle; back-to-back jobs
        step(1, 3, 0, 0, 0); step(1, 7, 0, 0, 0); step(1, 9, 0, 0, 0); idle(2);
        step(0, 0, 0, 1, 0); step(1, 6, 0, 0, 0); step(1, 2, 0, 0, 0);
        idle(5); step(0, 0, 0, 1, 0); idle(2);

        // largest job
        step(1, MAXLEN, 0, 0, 0); idle(MAXLEN + 3); step(0, 0, 0, 1, 0); idle(2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int l;
            bit s, st, fi, r;
            case ($urandom_range(7))
                0:       l = 0;
                1:       l = MAXLEN;
                default: l = int'($urandom_range(MAXLEN - 1, 1));
            endcase
            s  = ($urandom_range(3) == 0);
            st = ($urandom_range(2) == 0);
            fi = ($urandom_range(5) == 0);
            r  = ($urandom_range(299) == 0);
            step(s, l, st, fi, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
